contador_de_programa_pilha: RTL and testbench

- Parametrised program counter, the successor of the 4-bit SAP-1 PC.
- Adds configurable address width and a hardware return-address stack for CALL/RET.
- Keeps the increment, absolute jump and tri-state bus drive of the current PC.
- Sits between the control sequencer and the shared W-bit bus; drives the MAR address on PC_OUT.

---
 rtl/contador_de_programa_pilha.sv | 88 ++++++++
 tb/tb_contador_de_programa_pilha.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/contador_de_programa_pilha.sv
// Parametrised program counter with a hardware return-address stack for CALL/RET.
// Operation priority per edge: call > ret > jump > PC_INC; bus_out is a tri-state view of pc.
module contador_de_programa_pilha #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             PC_INC,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic             PC_OUT,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] pc,
  output logic [SPW-1:0]   sp,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [WIDTH-1:0] pc_nxt;
  logic [SPW-1:0]   sp_nxt;
  logic             err_nxt;
  logic             push;
  logic [IDXW-1:0]  push_idx;
  logic [IDXW-1:0]  pop_idx;

  assign stack_full  = (sp == SP_MAX);
  assign stack_empty = (sp == '0);
  assign push_idx    = IDXW'(sp);
  assign pop_idx     = IDXW'(sp - SPW'(1));
  assign bus_out     = PC_OUT ? pc : {WIDTH{1'bz}};

  // Only a literal 1 counts as a request, so unknown inputs fall through to hold.
  always_comb begin
    pc_nxt  = pc;
    sp_nxt  = sp;
    err_nxt = stack_err;
    push    = 1'b0;
    if (call == 1'b1) begin
      if (!stack_full) begin
        push   = 1'b1;
        sp_nxt = sp + SPW'(1);
        pc_nxt = bus_in;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (ret == 1'b1) begin
      if (!stack_empty) begin
        pc_nxt = stack_mem[pop_idx];
        sp_nxt = sp - SPW'(1);
      end else begin
        err_nxt = 1'b1;
      end
    end else if (jump == 1'b1) begin
      pc_nxt = bus_in;
    end else if (PC_INC == 1'b1) begin
      pc_nxt = pc + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pc        <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      sp        <= sp_nxt;
      stack_err <= err_nxt;
    end
  end

  // Stack storage carries no reset; entries above sp are never read.
  always_ff @(posedge clock) begin
    if (push && clear_n) begin
      stack_mem[push_idx] <= pc;
    end
  end

endmodule

// File: tb/tb_contador_de_programa_pilha.sv
// Self-checking bench for contador_de_programa_pilha (WIDTH=4, DEPTH=2).
// Directed vector table, hand-written reset/tri-state sequences, then random ops vs a queue model.
module tb_contador_de_programa_pilha;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic             clock;
  logic             clear_n;
  logic             PC_INC, jump, call, ret, PC_OUT;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] pc;
  logic [SPW-1:0]   sp;
  logic             stack_full, stack_empty, stack_err;

  contador_de_programa_pilha #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .PC_INC     (PC_INC),
    .jump       (jump),
    .call       (call),
    .ret        (ret),
    .PC_OUT     (PC_OUT),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .pc         (pc),
    .sp         (sp),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a plain integer PC and a queue used as the LIFO.
  int m_pc;
  int m_stack[$];
  bit m_err;

  typedef struct {
    bit       rst;
    bit       c, r, j, i;
    bit [3:0] bus;
    int       exp_pc;
    int       exp_sp;
    bit       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void add(input bit rst, input bit c, input bit r, input bit j, input bit i,
                              input bit [3:0] bus, input int epc, input int esp, input bit eerr);
    vec_t v;
    v.rst = rst; v.c = c; v.r = r; v.j = j; v.i = i; v.bus = bus;
    v.exp_pc = epc; v.exp_sp = esp; v.exp_err = eerr;
    vecs.push_back(v);
  endfunction

  function automatic void model_op(input bit c, input bit r, input bit j, input bit i, input int bus);
    if (c) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back(m_pc);
        m_pc = bus;
      end else m_err = 1'b1;
    end else if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_err = 1'b1;
    end else if (j) begin
      m_pc = bus;
    end else if (i) begin
      m_pc = (m_pc + 1) % (1 << WIDTH);
    end
  endfunction

  task automatic do_reset();
    @(negedge clock);
    clear_n = 1'b0;
    m_pc = 0; m_stack.delete(); m_err = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  // Drive a request just after a falling edge, clock it in, return at the next falling edge.
  task automatic step(input bit c, input bit r, input bit j, input bit i, input logic [3:0] bus);
    call = c; ret = r; jump = j; PC_INC = i; bus_in = bus;
    @(posedge clock);
    model_op(c, r, j, i, int'(bus));
    @(negedge clock);
  endtask

  initial begin
    clear_n = 1'b0;
    {PC_INC, jump, call, ret} = '0;
    PC_OUT = 1'b1;
    bus_in = '0;

    for (int k = 1; k <= 17; k++) add(0, 0, 0, 0, 1, 4'h0, k % 16, 0, 0);
    add(0, 0, 0, 1, 0, 4'h3, 3, 0, 0);
    add(0, 0, 0, 1, 0, 4'hA, 10, 0, 0);
    add(0, 0, 0, 1, 0, 4'h5, 5, 0, 0);
    add(0, 1, 0, 0, 0, 4'h8, 8, 1, 0);
    add(0, 1, 0, 0, 0, 4'hC, 12, 2, 0);
    add(0, 0, 1, 0, 0, 4'h0, 8, 1, 0);
    add(0, 0, 1, 0, 0, 4'h0, 5, 0, 0);
    add(0, 1, 0, 0, 0, 4'h8, 8, 1, 0);
    add(0, 1, 0, 0, 0, 4'hC, 12, 2, 0);
    add(0, 1, 0, 0, 0, 4'h1, 12, 2, 1);
    add(0, 0, 1, 0, 0, 4'h0, 8, 1, 1);
    add(1, 0, 0, 1, 0, 4'h2, 2, 0, 0);
    add(0, 1, 1, 1, 1, 4'h9, 9, 1, 0);
    add(0, 0, 1, 0, 1, 4'h0, 2, 0, 0);
    add(0, 0, 1, 0, 0, 4'h0, 2, 0, 1);

    #2;
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_sp", 32'(sp), 32'd0);
    chk("reset_err", 32'(stack_err), 32'd0);
    chk("reset_empty", 32'(stack_empty), 32'd1);
    do_reset();

    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      step(vecs[n].c, vecs[n].r, vecs[n].j, vecs[n].i, vecs[n].bus);
      chk($sformatf("vec%0d_pc", n), 32'(pc), 32'(vecs[n].exp_pc));
      chk($sformatf("vec%0d_sp", n), 32'(sp), 32'(vecs[n].exp_sp));
      chk($sformatf("vec%0d_err", n), 32'(stack_err), 32'(vecs[n].exp_err));
      chk($sformatf("vec%0d_full", n), 32'(stack_full), 32'(vecs[n].exp_sp == DEPTH));
      chk($sformatf("vec%0d_empty", n), 32'(stack_empty), 32'(vecs[n].exp_sp == 0));
    end

    // Tri-state view at pc=0xA.
    do_reset();
    step(0, 0, 1, 0, 4'hA);
    PC_OUT = 1'b0;
    #1;
    chk("bus_out_released", 32'(bus_out !== 4'hA), 32'd1);
    PC_OUT = 1'b1;
    #1;
    chk("bus_out_driven", 32'(bus_out), 32'hA);

    // Asynchronous reset between edges with sp=1, pc=7, err set, and call held high.
    do_reset();
    step(0, 1, 0, 0, 4'h0);
    step(0, 0, 1, 0, 4'h3);
    step(1, 0, 0, 0, 4'h7);
    chk("pre_areset_pc", 32'(pc), 32'h7);
    chk("pre_areset_err", 32'(stack_err), 32'd1);
    #1;
    call = 1'b1; bus_in = 4'hE;
    clear_n = 1'b0;
    #1;
    chk("areset_pc", 32'(pc), 32'd0);
    chk("areset_sp", 32'(sp), 32'd0);
    chk("areset_err", 32'(stack_err), 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("areset_hold_pc", 32'(pc), 32'd0);
    chk("areset_hold_sp", 32'(sp), 32'd0);
    call = 1'b0;
    clear_n = 1'b1;
    m_pc = 0; m_stack.delete(); m_err = 1'b0;
    step(0, 0, 0, 1, 4'h0);
    chk("post_release_pc", 32'(pc), 32'd1);

    // Random operations against the model.
    for (int t = 0; t < 400; t++) begin
      if (t == 200) do_reset();
      PC_OUT = 1'($urandom_range(0, 1));
      step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, 4'($urandom));
      chk($sformatf("rnd%0d_pc", t), 32'(pc), 32'(m_pc));
      chk($sformatf("rnd%0d_sp", t), 32'(sp), 32'(m_stack.size()));
      chk($sformatf("rnd%0d_err", t), 32'(stack_err), 32'(m_err));
      if (PC_OUT) chk($sformatf("rnd%0d_bus", t), 32'(bus_out), 32'(m_pc));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
